// File: rtl/data_memory_unit.sv
// Data-side memory stage: word RAM, free-running cycle counter and a
// memory-mapped output FIFO with a valid/ready drain port.
module data_memory_unit #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memw_m,
  input  logic [31:0] m_address,
  input  logic [31:0] m_data,
  output logic [31:0] input_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        fifo_full
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [29:0] CNT_W  = 30'h3FFF_C000;
  localparam logic [29:0] FIFO_W = 30'h3FFF_C001;
  localparam logic [29:0] STAT_W = 30'h3FFF_C002;

  localparam logic [FW:0] DEPTH_C = FIFO_DEPTH[FW:0];

  logic [31:0]   ram  [RAM_WORDS];
  logic [31:0]   fifo [FIFO_DEPTH];

  logic [FW-1:0] rp;
  logic [FW-1:0] wp;
  logic [FW:0]   count;
  logic          ovf;
  logic [31:0]   cyc_cnt;

  logic [31:0]   ram_q;
  logic [31:0]   io_q;
  logic          ram_sel_q;

  logic          hit_ram;
  logic          hit_cnt;
  logic          hit_fifo;
  logic          hit_stat;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW-1:0] idx;
  logic [31:0]   io_d;
  logic          unused;

  assign unused   = ^m_address[1:0];
  assign idx      = m_address[AW+1:2];
  assign hit_ram  = (m_address[31:AW+2] == '0);
  assign hit_cnt  = (m_address[31:2] == CNT_W);
  assign hit_fifo = (m_address[31:2] == FIFO_W);
  assign hit_stat = (m_address[31:2] == STAT_W);

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign pop      = !empty && out_ready;
  assign push_req = memw_m && hit_fifo && !rst;
  // A full FIFO still takes a push when the head leaves the same cycle
  assign push     = push_req && (!full || pop);

  assign out_valid = !empty;
  assign out_data  = fifo[rp];
  assign fifo_full = full;

  always_comb begin
    io_d = '0;
    unique case (1'b1)
      hit_cnt:  io_d = cyc_cnt;
      hit_fifo: io_d = 32'(count);
      hit_stat: io_d = {29'd0, ovf, empty, full};
      default:  io_d = '0;
    endcase
  end

  // Read-first RAM, contents not reset
  always_ff @(posedge clk) begin
    if (memw_m && hit_ram && !rst)
      ram[idx] <= m_data;
    ram_q <= ram[idx];
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wp] <= m_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      cyc_cnt   <= '0;
      io_q      <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      cyc_cnt   <= cyc_cnt + 32'd1;
      io_q      <= io_d;
      ram_sel_q <= hit_ram;
      if (pop)
        rp <= rp + 1'b1;
      if (push)
        wp <= wp + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (memw_m && hit_stat)
        ovf <= 1'b0;
      else if (push_req && !push)
        ovf <= 1'b1;
    end
  end

  assign input_data = ram_sel_q ? ram_q : io_q;

endmodule
